// File: rtl/cpu_bus_ctrl.sv
// cpu_bus_ctrl: bus controller behind the cpu core. Decodes each access into work RAM
// (mirrored), open bus or PRG ROM (req/ack port) and holds read data while the core
// keeps presenting the same address.
// Optional feature: define BUS_TIMEOUT_EN to abort ROM requests after ROM_TIMEOUT cycles.
module cpu_bus_ctrl #(
    parameter int unsigned RAM_BYTES   = 2048,
    parameter int unsigned ROM_TIMEOUT = 255
) (
    input  logic        clock_i,
    input  logic        reset_ni,
    input  logic [15:0] cpu_address_i,
    input  logic        cpu_address_valid_i,
    input  logic        cpu_write_i,
    input  logic [7:0]  cpu_data_i,
    output logic [7:0]  cpu_data_o,
    output logic        cpu_data_valid_o,
    output logic [14:0] rom_address_o,
    output logic        rom_request_o,
    input  logic [7:0]  rom_data_i,
    input  logic        rom_ack_i,
    output logic        timeout_o
);

    localparam int unsigned RamAw = $clog2(RAM_BYTES);

    typedef enum logic [1:0] {StIdle, StRamRd, StRomReq, StHold} state_e;

    state_e      state_q, state_d;
    // Registered copies of the core and ROM inputs; the FSM acts on these.
    logic [15:0] in_addr_q;
    logic        in_valid_q, in_write_q;
    logic [7:0]  in_wdata_q;
    logic        rom_ack_q;
    logic [7:0]  rom_rdata_q;

    logic [15:0] lat_addr_q, lat_addr_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic [14:0] rom_addr_q, rom_addr_d;
    logic        req_q, req_d;
    logic [7:0]  open_bus_q, open_bus_d;
    logic        ram_we;

    logic [7:0]  ram_q [RAM_BYTES];
    logic [7:0]  ram_rdata_q;
    logic [RamAw-1:0] ram_idx;
    logic        in_is_ram, in_is_rom;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(ROM_TIMEOUT);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
`else
    logic unused_rom_timeout;
    assign unused_rom_timeout = ^ROM_TIMEOUT;
`endif

    assign ram_idx   = in_addr_q[RamAw-1:0];
    assign in_is_ram = (in_addr_q[15:13] == 3'b000);
    assign in_is_rom = in_addr_q[15];

    // Work RAM: one write port, one registered read port (contents not reset).
    always_ff @(posedge clock_i) begin
        if (ram_we) begin
            ram_q[ram_idx] <= in_wdata_q;
        end
        ram_rdata_q <= ram_q[ram_idx];
    end

    // State, input capture and output registers.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            in_addr_q   <= '0;
            in_valid_q  <= 1'b0;
            in_write_q  <= 1'b0;
            in_wdata_q  <= '0;
            rom_ack_q   <= 1'b0;
            rom_rdata_q <= '0;
            lat_addr_q  <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            rom_addr_q  <= '0;
            req_q       <= 1'b0;
            open_bus_q  <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            in_addr_q   <= cpu_address_i;
            in_valid_q  <= cpu_address_valid_i;
            in_write_q  <= cpu_write_i;
            in_wdata_q  <= cpu_data_i;
            // Only acks arriving while a request is out count; strays are dropped here.
            rom_ack_q   <= rom_ack_i & req_q;
            rom_rdata_q <= rom_data_i;
            lat_addr_q  <= lat_addr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            rom_addr_q  <= rom_addr_d;
            req_q       <= req_d;
            open_bus_q  <= open_bus_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        lat_addr_d = lat_addr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        rom_addr_d = rom_addr_q;
        req_d      = req_q;
        open_bus_d = open_bus_q;
        ram_we     = 1'b0;
`ifdef BUS_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid_q && in_write_q) begin
                    open_bus_d = in_wdata_q;
                    ram_we     = in_is_ram;
                end else if (in_valid_q) begin
                    lat_addr_d = in_addr_q;
                    if (in_is_ram) begin
                        state_d = StRamRd;
                    end else if (in_is_rom) begin
                        req_d      = 1'b1;
                        rom_addr_d = in_addr_q[14:0];
                        state_d    = StRomReq;
`ifdef BUS_TIMEOUT_EN
                        cnt_d      = '0;
`endif
                    end else begin
                        data_d  = open_bus_q;
                        valid_d = 1'b1;
                        state_d = StHold;
                    end
                end
            end
            StRamRd: begin
                data_d     = ram_rdata_q;
                open_bus_d = ram_rdata_q;
                valid_d    = 1'b1;
                state_d    = StHold;
            end
            StRomReq: begin
                if (rom_ack_q) begin
                    data_d     = rom_rdata_q;
                    open_bus_d = rom_rdata_q;
                    req_d      = 1'b0;
                    valid_d    = 1'b1;
                    state_d    = StHold;
                end
`ifdef BUS_TIMEOUT_EN
                else if (cnt_q == CntW'(ROM_TIMEOUT - 1)) begin
                    data_d    = open_bus_q;
                    req_d     = 1'b0;
                    valid_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = StHold;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StHold: begin
                if (!in_valid_q || in_write_q || (in_addr_q != lat_addr_q)) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                    if (in_valid_q && in_write_q) begin
                        open_bus_d = in_wdata_q;
                        ram_we     = in_is_ram;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign cpu_data_o       = data_q;
    assign cpu_data_valid_o = valid_q;
    assign rom_address_o    = rom_addr_q;
    assign rom_request_o    = req_q;
`ifdef BUS_TIMEOUT_EN
    assign timeout_o        = timeout_q;
`else
    assign timeout_o        = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Scoreboard bench for cpu_bus_ctrl: stimulus pushes expected read data and the cycle
// at which cpu_data_valid_o must rise; a negedge monitor pops and compares.
module tb_cpu_bus_ctrl;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TbTimeout = 4;
    localparam int AckDly1   = 3;
    localparam int ExpPulses = 1;
`else
    localparam int unsigned TbTimeout = 255;
    localparam int AckDly1   = 5;
    localparam int ExpPulses = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr = '0;
    logic        avalid = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic        dvalid;
    logic [14:0] rom_addr;
    logic        rom_req;
    logic [7:0]  rom_data = '0;
    logic        rom_ack = 1'b0;
    logic        tmo;

    cpu_bus_ctrl #(
        .RAM_BYTES  (2048),
        .ROM_TIMEOUT(TbTimeout)
    ) dut (
        .clock_i            (clk),
        .reset_ni           (rst_n),
        .cpu_address_i      (addr),
        .cpu_address_valid_i(avalid),
        .cpu_write_i        (wr),
        .cpu_data_i         (wdata),
        .cpu_data_o         (rdata),
        .cpu_data_valid_o   (dvalid),
        .rom_address_o      (rom_addr),
        .rom_request_o      (rom_req),
        .rom_data_i         (rom_data),
        .rom_ack_i          (rom_ack),
        .timeout_o          (tmo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         at_cyc;
    } exp_t;
    exp_t exp_q[$];

    int   errors = 0;
    int   checks = 0;
    int   req_rises = 0;
    int   to_pulses = 0;
    logic prev_valid = 1'b0;
    logic prev_req = 1'b0;

    // Monitor: every rising edge of cpu_data_valid_o must match the next expectation.
    always @(negedge clk) begin
        if (rst_n && dvalid && !prev_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got data=%h at cyc %0d, required no read", rdata,
                         cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rdata !== e.data || cyc != e.at_cyc) begin
                    errors++;
                    $display("FAIL read_data: got %h at cyc %0d, required %h at cyc %0d", rdata,
                             cyc, e.data, e.at_cyc);
                end
            end
        end
        if (rom_req && !prev_req) req_rises++;
        if (tmo) to_pulses++;
        prev_valid <= dvalid;
        prev_req   <= rom_req;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) tick(1);
    endtask

    task automatic push(input logic [7:0] d, input int c);
        exp_t e;
        e.data   = d;
        e.at_cyc = c;
        exp_q.push_back(e);
    endtask

    // extra = 1 when the bus is leaving HOLD, which costs one cycle before sampling.
    task automatic rom_read(input logic [15:0] a, input int dly, input logic [7:0] d,
                            input int extra);
        int k, n, s;
        k = cyc;
        addr = a;
        avalid = 1'b1;
        n = k + 1 + extra;
        s = n + 1 + dly;
        push(d, s + 1);
        if (extra != 0) begin
            tick(2);
            check("hold_drop", {15'd0, dvalid}, 16'd0);
        end
        wait_cyc(s - 1);
        check("rom_req", {15'd0, rom_req}, 16'd1);
        check("rom_addr", {1'b0, rom_addr}, {1'b0, a[14:0]});
        rom_data = d;
        rom_ack = 1'b1;
        tick(1);
        rom_ack = 1'b0;
        rom_data = '0;
        wait_cyc(s + 2);
    endtask

    task automatic ram_read(input logic [15:0] a, input logic [7:0] d, input int extra);
        int n;
        n = cyc + 1 + extra;
        addr = a;
        avalid = 1'b1;
        push(d, n + 2);
        wait_cyc(n + 4);
    endtask

    task automatic unm_read(input logic [15:0] a, input logic [7:0] d, input int extra);
        int n;
        n = cyc + 1 + extra;
        addr = a;
        avalid = 1'b1;
        push(d, n + 1);
        wait_cyc(n + 3);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        addr = a;
        avalid = 1'b1;
        wr = 1'b1;
        wdata = d;
        tick(1);
        wr = 1'b0;
        avalid = 1'b0;
        tick(2);
    endtask

    task automatic idle_bus();
        avalid = 1'b0;
        tick(3);
    endtask

    initial begin
        int r0;
        int k;
        tick(2);
        check("rst_data", {8'd0, rdata}, 16'd0);
        check("rst_valid", {15'd0, dvalid}, 16'd0);
        check("rst_rom_addr", {1'b0, rom_addr}, 16'd0);
        check("rst_rom_req", {15'd0, rom_req}, 16'd0);
        check("rst_timeout", {15'd0, tmo}, 16'd0);
        rst_n = 1'b1;
        tick(2);

        // ROM fetch of the reset vector, then a second ROM address from HOLD.
        rom_read(16'hFFFC, AckDly1, 8'h34, 0);
        tick(3);
        check("hold_valid", {15'd0, dvalid}, 16'd1);
        check("hold_data", {8'd0, rdata}, 16'h0034);
        rom_read(16'hFFFD, 2, 8'h12, 1);

        // Unmapped read returns the last bus value without touching ROM.
        r0 = req_rises;
        unm_read(16'h4000, 8'h12, 1);
        check("unmapped_no_rom", 16'(req_rises), 16'(r0));

        // RAM write and mirrored reads.
        bus_write(16'h0005, 8'hA5);
        ram_read(16'h0805, 8'hA5, 0);
        ram_read(16'h1805, 8'hA5, 1);

        // ROM-region write is discarded but still lands on the open bus.
        r0 = req_rises;
        bus_write(16'h9000, 8'h3C);
        check("rom_write_no_req", 16'(req_rises), 16'(r0));
        unm_read(16'h2000, 8'h3C, 0);
        ram_read(16'h0005, 8'hA5, 1);

        // Top of the RAM mirror.
        bus_write(16'h07FF, 8'h5A);
        ram_read(16'h1FFF, 8'h5A, 0);
        idle_bus();

        // Reset while a ROM request is outstanding; a later ack must be ignored.
        k = cyc;
        addr = 16'h8000;
        avalid = 1'b1;
        wait_cyc(k + 3);
        check("req_before_rst", {15'd0, rom_req}, 16'd1);
        #2;
        rst_n = 1'b0;
        avalid = 1'b0;
        #1;
        check("req_async_clr", {15'd0, rom_req}, 16'd0);
        tick(2);
        rst_n = 1'b1;
        rom_data = 8'hEE;
        rom_ack = 1'b1;
        tick(1);
        rom_ack = 1'b0;
        rom_data = '0;
        tick(4);
        check("stray_ack_valid", {15'd0, dvalid}, 16'd0);

`ifdef BUS_TIMEOUT_EN
        // Prime the open bus, then let a ROM request expire.
        ram_read(16'h0005, 8'hA5, 0);
        idle_bus();
        k = cyc;
        addr = 16'hC000;
        avalid = 1'b1;
        push(8'hA5, k + 6);
        wait_cyc(k + 6);
        check("timeout_pulse", {15'd0, tmo}, 16'd1);
        check("timeout_req_drop", {15'd0, rom_req}, 16'd0);
        tick(1);
        check("timeout_once", {15'd0, tmo}, 16'd0);
        idle_bus();
        // Ack on the expiry cycle wins.
        rom_read(16'hC001, 3, 8'h77, 0);
        idle_bus();
`endif

        tick(3);
        check("timeout_pulses", 16'(to_pulses), 16'(ExpPulses));
        check("sb_empty", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
